// File: rtl/score_seg_pkg.sv
// Shared seven-segment score definitions for the score display encoder and decoder.
// Patterns are {g,f,e,d,c,b,a}, active-low.
package score_seg_pkg;

  typedef logic [3:0] score_code_t;
  typedef logic [6:0] seg_pat_t;

  localparam seg_pat_t SEG_BLANK = 7'b1111111;

  localparam seg_pat_t SEG_0  = 7'b0001000;
  localparam seg_pat_t SEG_1  = 7'b0010000;
  localparam seg_pat_t SEG_2  = 7'b0000000;
  localparam seg_pat_t SEG_3  = 7'b1011000;
  localparam seg_pat_t SEG_4  = 7'b0000010;
  localparam seg_pat_t SEG_5  = 7'b0010010;
  localparam seg_pat_t SEG_6  = 7'b0011001;
  localparam seg_pat_t SEG_7  = 7'b0110000;
  localparam seg_pat_t SEG_8  = 7'b0100100;
  localparam seg_pat_t SEG_9  = 7'b1111001;
  localparam seg_pat_t SEG_10 = 7'b1000000;
  localparam seg_pat_t SEG_11 = 7'b0000011;
  localparam seg_pat_t SEG_12 = 7'b1000110;
  localparam seg_pat_t SEG_13 = 7'b0100001;
  localparam seg_pat_t SEG_14 = 7'b0000110;
  localparam seg_pat_t SEG_15 = 7'b0001110;

  // Forward mapping used by the encoder side.
  function automatic seg_pat_t seg_encode(input score_code_t c);
    seg_pat_t p;
    case (c)
      4'd0:    p = SEG_0;
      4'd1:    p = SEG_1;
      4'd2:    p = SEG_2;
      4'd3:    p = SEG_3;
      4'd4:    p = SEG_4;
      4'd5:    p = SEG_5;
      4'd6:    p = SEG_6;
      4'd7:    p = SEG_7;
      4'd8:    p = SEG_8;
      4'd9:    p = SEG_9;
      4'd10:   p = SEG_10;
      4'd11:   p = SEG_11;
      4'd12:   p = SEG_12;
      4'd13:   p = SEG_13;
      4'd14:   p = SEG_14;
      default: p = SEG_15;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/score_seg_lookup.sv
// Combinational reverse lookup: segment pattern to score code plus a hit flag.
module score_seg_lookup
  import score_seg_pkg::*;
(
  input  seg_pat_t    pat_i,
  output logic        hit_o,
  output score_code_t code_o
);

  always_comb begin
    hit_o  = 1'b1;
    code_o = 4'd0;
    case (pat_i)
      SEG_0:   code_o = 4'd0;
      SEG_1:   code_o = 4'd1;
      SEG_2:   code_o = 4'd2;
      SEG_3:   code_o = 4'd3;
      SEG_4:   code_o = 4'd4;
      SEG_5:   code_o = 4'd5;
      SEG_6:   code_o = 4'd6;
      SEG_7:   code_o = 4'd7;
      SEG_8:   code_o = 4'd8;
      SEG_9:   code_o = 4'd9;
      SEG_10:  code_o = 4'd10;
      SEG_11:  code_o = 4'd11;
      SEG_12:  code_o = 4'd12;
      SEG_13:  code_o = 4'd13;
      SEG_14:  code_o = 4'd14;
      SEG_15:  code_o = 4'd15;
      default: hit_o  = 1'b0;
    endcase
  end

endmodule

// File: rtl/score_segment_decoder.sv
// Debounces the multiplexed segment bus and decodes each stable digit into a per-digit slot.
// Define SCORE_DEC_BLANK_EN to treat an all-off pattern as blank instead of a decode error.
module score_segment_decoder
  import score_seg_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int IDX_W         = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_n,
  input  logic [DIGITS-1:0]     dig_sel,
  input  logic                  err_clr,
  output logic [4*DIGITS-1:0]   code,
  output logic [DIGITS-1:0]     code_valid,
  output logic [DIGITS-1:0]     err,
  output logic                  upd,
  output logic [IDX_W-1:0]      upd_idx
);

  localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES);
  localparam logic [3:0] CNT_CAP = 4'(STABLE_CYCLES - 1);
`ifdef SCORE_DEC_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  seg_pat_t          seg_q;
  logic [DIGITS-1:0] sel_q;
  logic [3:0]        cnt_q, cnt_d;
  logic              upd_q;
  logic [IDX_W-1:0]  upd_idx_q, cap_idx;
  logic              same, stable, capture, is_blank;
  logic              lk_hit;
  score_code_t       lk_code;

  assign same     = (seg_n == seg_q) && (dig_sel == sel_q);
  assign stable   = same && $onehot(dig_sel);
  assign capture  = stable && (cnt_q == CNT_CAP);
  assign is_blank = (seg_q == SEG_BLANK);

  // Saturating at STABLE_CYCLES keeps a held pattern from capturing twice.
  always_comb begin
    cnt_d = 4'd0;
    if (stable) cnt_d = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + 4'd1;
  end

  always_comb begin
    cap_idx = '0;
    for (int i = 0; i < DIGITS; i++)
      if (dig_sel[i]) cap_idx = IDX_W'(i);
  end

  // seg_q equals seg_n whenever capture is high, so decode from the register.
  score_seg_lookup u_lookup (
    .pat_i  (seg_q),
    .hit_o  (lk_hit),
    .code_o (lk_code)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q     <= SEG_BLANK;
      sel_q     <= '0;
      cnt_q     <= 4'd0;
      upd_q     <= 1'b0;
      upd_idx_q <= '0;
    end else begin
      seg_q <= seg_n;
      sel_q <= dig_sel;
      cnt_q <= cnt_d;
      upd_q <= capture;
      if (capture) upd_idx_q <= cap_idx;
    end
  end

  for (genvar d = 0; d < DIGITS; d++) begin : g_slot
    score_code_t code_r;
    logic        vld_r, err_r;
    logic        cap_here, hit_cap, blank_cap, miss_cap;

    assign cap_here  = capture && dig_sel[d];
    assign hit_cap   = cap_here && lk_hit;
    assign blank_cap = cap_here && !lk_hit && is_blank && BLANK_EN;
    assign miss_cap  = cap_here && !lk_hit && !(is_blank && BLANK_EN);

    always_ff @(posedge clk) begin
      if (rst) begin
        code_r <= 4'd0;
        vld_r  <= 1'b0;
        err_r  <= 1'b0;
      end else begin
        if (hit_cap) begin
          code_r <= lk_code;
          vld_r  <= 1'b1;
        end else if (blank_cap) begin
          vld_r  <= 1'b0;
        end
        // A miss landing with err_clr keeps the flag set.
        if (miss_cap)     err_r <= 1'b1;
        else if (err_clr) err_r <= 1'b0;
      end
    end

    assign code[4*d +: 4] = code_r;
    assign code_valid[d]  = vld_r;
    assign err[d]         = err_r;
  end

  assign upd     = upd_q;
  assign upd_idx = upd_idx_q;

endmodule

// File: tb/tb_score_segment_decoder.sv
// Directed table-driven bench for score_segment_decoder (DIGITS=4, STABLE_CYCLES=4).
module tb_score_segment_decoder;

`ifdef SCORE_DEC_BLANK_EN
  localparam bit B = 1'b1;
`else
  localparam bit B = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg_n = 7'h7F;
  logic [3:0]  dig_sel = 4'b0000;
  logic        err_clr = 1'b0;
  logic [15:0] code;
  logic [3:0]  code_valid, err;
  logic        upd;
  logic [1:0]  upd_idx;

  score_segment_decoder #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .seg_n(seg_n), .dig_sel(dig_sel), .err_clr(err_clr),
    .code(code), .code_valid(code_valid), .err(err), .upd(upd), .upd_idx(upd_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  seg;
    logic [3:0]  sel;
    int          hold;
    bit          clr;
    logic [15:0] code;
    logic [3:0]  vld;
    logic [3:0]  err;
    int          upds;
    int          idx;
  } vec_t;

  vec_t vt[$];
  logic [6:0] pat_tb [16] = '{7'b0001000, 7'b0010000, 7'b0000000, 7'b1011000,
                             7'b0000010, 7'b0010010, 7'b0011001, 7'b0110000,
                             7'b0100100, 7'b1111001, 7'b1000000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  int n_chk = 0, n_pass = 0, upd_n = 0, last_idx = 0, scan_upds = 0;

  task automatic chk(input string name, input int v, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s vec %0d: got %0h expected %0h", name, v, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (upd) begin
      upd_n++;
      last_idx = int'(upd_idx);
    end
  endtask

  task automatic add(input logic [6:0] s, input logic [3:0] sel, input int h, input bit c,
                     input logic [15:0] ec, input logic [3:0] ev, input logic [3:0] ee,
                     input int eu, input int ei);
    vec_t x;
    x.seg = s; x.sel = sel; x.hold = h; x.clr = c;
    x.code = ec; x.vld = ev; x.err = ee; x.upds = eu; x.idx = ei;
    vt.push_back(x);
  endtask

  initial begin
    logic [15:0] c;
    logic [3:0]  v6, v;
    v6 = B ? 4'b0001 : 4'b0101;

    add(7'b0010010, 4'b0001,  5, 0, 16'h0005, 4'b0001, 4'b0000, 1, 0);
    add(7'h7F,      4'b0000,  2, 0, 16'h0005, 4'b0001, 4'b0000, 0, 0);
    add(7'b0010010, 4'b0010,  4, 0, 16'h0005, 4'b0001, 4'b0000, 0, 0);
    add(7'h7F,      4'b0000,  1, 0, 16'h0005, 4'b0001, 4'b0000, 0, 0);
    add(7'b0110000, 4'b0100,  5, 0, 16'h0705, 4'b0101, 4'b0000, 1, 2);
    add(7'h7F,      4'b0100,  5, 0, 16'h0705, v6, B ? 4'b0000 : 4'b0100, 1, 2);
    add(7'b1010101, 4'b1000,  5, 0, 16'h0705, v6, B ? 4'b1000 : 4'b1100, 1, 3);
    add(7'h7F,      4'b0000,  1, 0, 16'h0705, v6, B ? 4'b1000 : 4'b1100, 0, 0);
    add(7'b1010101, 4'b1000,  5, 1, 16'h0705, v6, 4'b1000, 1, 3);
    add(7'h7F,      4'b0000,  1, 1, 16'h0705, v6, 4'b0000, 0, 0);
    add(7'b0100100, 4'b0001,  3, 0, 16'h0705, v6, 4'b0000, 0, 0);
    add(7'b0100100, 4'b0010,  5, 0, 16'h0785, v6 | 4'b0010, 4'b0000, 1, 1);
    add(7'b0000000, 4'b0011, 20, 0, 16'h0785, v6 | 4'b0010, 4'b0000, 0, 0);
    add(7'h7F,      4'b0000,  1, 0, 16'h0785, v6 | 4'b0010, 4'b0000, 0, 0);
    add(7'b0000110, 4'b0001, 12, 0, 16'h078E, v6 | 4'b0010, 4'b0000, 1, 0);
    c = 16'h078E;
    v = v6 | 4'b0010;
    for (int k = 0; k < 16; k++) begin
      c[4*(k%4) +: 4] = 4'(k);
      v[k%4] = 1'b1;
      add(pat_tb[k], 4'(1 << (k%4)), 6, 0, c, v, 4'b0000, 1, k%4);
    end

    // Reset state
    tick(); tick();
    chk("rst_code", -1, 32'(code), 0);
    chk("rst_valid", -1, 32'(code_valid), 0);
    chk("rst_err", -1, 32'(err), 0);
    chk("rst_upd", -1, 32'(upd), 0);
    chk("rst_idx", -1, 32'(upd_idx), 0);
    rst = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      seg_n = vt[i].seg;
      dig_sel = vt[i].sel;
      upd_n = 0;
      for (int e = 0; e < vt[i].hold; e++) begin
        err_clr = vt[i].clr && (e == vt[i].hold - 1);
        tick();
      end
      err_clr = 1'b0;
      if (i >= vt.size() - 16) scan_upds += upd_n;
      chk("code", i, 32'(code), 32'(vt[i].code));
      chk("valid", i, 32'(code_valid), 32'(vt[i].vld));
      chk("err", i, 32'(err), 32'(vt[i].err));
      chk("upd_count", i, 32'(upd_n), 32'(vt[i].upds));
      if (vt[i].upds > 0) chk("upd_idx", i, 32'(last_idx), 32'(vt[i].idx));
    end
    chk("scan_upds", 99, 32'(scan_upds), 16);
    chk("scan_code", 99, 32'(code), 32'h0000FEDC);

    // Reset in the middle of a run discards the partial run.
    seg_n = 7'b1111001;
    dig_sel = 4'b0100;
    upd_n = 0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("midrst_code", 100, 32'(code), 0);
    chk("midrst_valid", 100, 32'(code_valid), 0);
    chk("midrst_upd", 100, 32'(upd), 0);
    chk("midrst_idx", 100, 32'(upd_idx), 0);
    rst = 1'b0;
    upd_n = 0;
    repeat (4) tick();
    chk("midrst_partial_upd", 101, 32'(upd_n), 0);
    chk("midrst_partial_valid", 101, 32'(code_valid), 0);
    tick();
    chk("midrst_cap_upd", 102, 32'(upd_n), 1);
    chk("midrst_cap_code", 102, 32'(code), 32'h00000900);
    chk("midrst_cap_valid", 102, 32'(code_valid), 32'b0100);
    chk("midrst_cap_idx", 102, 32'(last_idx), 2);
    tick();
    chk("upd_one_cycle", 103, 32'(upd), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/score_segment_decoder.md
# score_segment_decoder

Reverse path of the score display encoder: samples the multiplexed, active-low seven-segment bus and digit strobes, debounces each pattern, and decodes it back into the 4-bit score code. Each decoded digit is held in a per-digit slot with a valid flag. Used for display self-test and loopback checking of the score path, between the segment driver pins and the test/status logic.

## Interface
Parameters:
- DIGITS, 4, number of multiplexed digits; legal range 1..8
- STABLE_CYCLES, 4, consecutive matching samples required before capture; legal range 2..15
- IDX_W, $clog2(DIGITS) with a minimum of 1, width of upd_idx

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- seg_n  in  7  segment bus {g,f,e,d,c,b,a}, active-low
- dig_sel  in  DIGITS  digit strobe, one-hot, active-high
- err_clr  in  1  clears all err bits
- code  out  4*DIGITS  decoded code per digit; digit d is at [4d+3:4d]
- code_valid  out  DIGITS  per-digit slot holds a valid decode
- err  out  DIGITS  sticky flag; an undecodable stable pattern was seen on that digit
- upd  out  1  one-cycle pulse on every capture event (valid, blank or error)
- upd_idx  out  IDX_W  digit index of the last capture

## Operation
- Sample register `s` holds {seg_n, dig_sel} and loads every cycle.
- Stability counter `cnt` (4 bits):
  - If the current inputs equal `s` and dig_sel is one-hot: `cnt <= min(cnt+1, STABLE_CYCLES)`.
  - Otherwise: `cnt <= 0`.
- Capture fires when `cnt == STABLE_CYCLES-1` and the inputs equal `s` with dig_sel one-hot.
  - A capture fires only once per stable run. The counter then saturates, so a held pattern does not re-capture.
- Decode table, pattern to code:
  - 0001000→0, 0010000→1, 0000000→2, 1011000→3
  - 0000010→4, 0010010→5, 0011001→6, 0110000→7
  - 0100100→8, 1111001→9, 1000000→10, 0000011→11
  - 1000110→12, 0100001→13, 0000110→14, 0001110→15
- On capture, with d = index of the active dig_sel bit:
  - Table hit: code[d] <= decoded value; code_valid[d] <= 1; err[d] is unchanged.
  - Miss: err[d] <= 1; code[d] and code_valid[d] are unchanged.
  - Blank pattern 1111111: see Configuration.
  - In all three cases: upd <= 1 and upd_idx <= d.
- dig_sel of zero or with multiple bits set: counter is cleared and no capture occurs.
- A change on seg_n or dig_sel alone restarts the run.
- err_clr clears every err bit. If a miss capture happens in the same cycle, the set wins for that digit.

## Timing
- Reset values:
  - code = 0, code_valid = 0, err = 0, upd = 0, upd_idx = 0
  - cnt = 0, s = {7'h7F, 0}
- Latency: if the inputs first change to a new value at edge e0 and are held, the outputs update at edge e0+STABLE_CYCLES.
  - The pattern must be present for STABLE_CYCLES+1 consecutive edges to capture.
- upd is high for exactly one cycle per capture.
- Capture events are at least STABLE_CYCLES+1 cycles apart.
- rst asserted mid-run returns every register to its reset value on that edge. A partial run is discarded.

## Configuration
- SCORE_DEC_BLANK_EN:
  - Defined: a stable 1111111 is treated as blank. It clears code_valid[d], leaves code[d] and err[d] unchanged, and pulses upd.
  - Undefined: 1111111 is treated as a table miss and sets err[d].

## Structure
- Shared package score_seg_pkg holds:
  - typedef score_code_t (4 bits) and typedef seg_pat_t (7 bits)
  - constant SEG_BLANK
  - the 16 pattern constants, shared with the encoder side
- One sub-module, score_seg_lookup: combinational seg_pat_t → {hit, score_code_t}.
- The top module holds the sample register, the counter, the slots and the flags.

## Test plan
- Reset, then hold seg_n=0010010 with dig_sel=0001 for 5 edges → code[3:0]=5, code_valid=0001, upd pulses once with upd_idx=0.
- Same pattern held for only 4 edges, then changed → no upd; code stays 0.
- seg_n=1111111 held 5 edges on dig_sel=0100:
  - Macro defined: code_valid[2]=0, err=0.
  - Macro undefined: err=0100.
- seg_n=1010101 held on dig_sel=1000 → err=1000; then err_clr and a miss in the same cycle → err stays 1000.
- dig_sel=0011 held 20 cycles → no upd. Then scan all 16 patterns across the 4 digits, 6 edges each → every code matches the table; upd count = 16.
